// File: rtl/vinstr_queue_pkg.sv
// vinstr_queue_pkg: vector opcode constants, packet field offsets and packet classification
package vinstr_queue_pkg;
  localparam logic [6:0] OPC_VARITH = 7'b1010111;
  localparam logic [6:0] OPC_VLOAD = 7'b0000111;
  localparam logic [6:0] OPC_VSTORE = 7'b0100111;
  localparam logic [2:0] FUNCT3_OPCFG = 3'b111;
  localparam int INSTR_LSB = 64;
  localparam int DATA2_LSB = 32;
  localparam int DATA1_LSB = 0;
  typedef enum logic [1:0] {CLS_ILLEGAL, CLS_VECTOR, CLS_VSET} vcls_t;
  function automatic vcls_t classify(input logic [6:0] opc, input logic [2:0] f3);
    return (opc == OPC_VARITH && f3 == FUNCT3_OPCFG) ? CLS_VSET :
           (opc == OPC_VARITH || opc == OPC_VLOAD || opc == OPC_VSTORE) ? CLS_VECTOR : CLS_ILLEGAL;
  endfunction
endpackage

// File: rtl/vqueue_mem.sv
// vqueue_mem: DEPTH x W register array (i_we/i_waddr/i_wdata write port, i_raddr -> o_rdata async read), no reset
module vqueue_mem #(
  parameter int DEPTH = 4,
  parameter int W = 96,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/vinstr_queue.sv
// vinstr_queue: vector instruction FIFO (valid_i/ready_o in, valid_o/ready_i out, flush_i) dropping non-vector packets, reporting occupancy_o/vset_cnt_o/drop_o
module vinstr_queue #(
  parameter int DEPTH = 4,
  parameter int DATA_FROM_SCALAR = 96
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [DATA_FROM_SCALAR-1:0]   vector_instructions_i,
  input  logic                          flush_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [DATA_FROM_SCALAR-1:0]   vector_instructions_o,
  output logic [$clog2(DEPTH):0]        occupancy_o,
  output logic [$clog2(DEPTH):0]        vset_cnt_o,
  output logic                          drop_o
);
  import vinstr_queue_pkg::*;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] r_head, r_tail;
  logic [CW-1:0] r_occ, r_vcnt;
  logic r_drop;
  logic [DATA_FROM_SCALAR-1:0] w_head_word;
  vcls_t w_cls_in, w_cls_out;
  logic w_push, w_pop, w_wr, w_vin, w_vout;
  always_comb begin
    w_cls_in = classify(vector_instructions_i[INSTR_LSB +: 7], vector_instructions_i[INSTR_LSB+12 +: 3]);
    w_cls_out = classify(w_head_word[INSTR_LSB +: 7], w_head_word[INSTR_LSB+12 +: 3]);
    w_push = valid_i & ready_o;
    w_pop = valid_o & ready_i;
    w_wr = w_push & (w_cls_in != CLS_ILLEGAL) & ~flush_i;
    w_vin = w_wr & (w_cls_in == CLS_VSET);
    w_vout = w_pop & (w_cls_out == CLS_VSET);
  end
  always_ff @(posedge clk)
    if (rst || flush_i) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ <= '0;
      r_vcnt <= '0;
      r_drop <= 1'b0;
    end else begin
      if (w_wr) r_tail <= r_tail + AW'(1);
      if (w_pop) r_head <= r_head + AW'(1);
      r_occ <= r_occ + CW'(w_wr) - CW'(w_pop);
      r_vcnt <= r_vcnt + CW'(w_vin) - CW'(w_vout);
      r_drop <= w_push & (w_cls_in == CLS_ILLEGAL);
    end
  vqueue_mem #(.DEPTH(DEPTH), .W(DATA_FROM_SCALAR)) u_mem (
    .clk(clk),
    .i_we(w_wr),
    .i_waddr(r_tail),
    .i_wdata(vector_instructions_i),
    .i_raddr(r_head),
    .o_rdata(w_head_word)
  );
  assign ready_o = r_occ != CW'(DEPTH);
  assign valid_o = r_occ != '0;
  assign occupancy_o = r_occ;
  assign vset_cnt_o = r_vcnt;
  assign drop_o = r_drop;
  assign vector_instructions_o = w_head_word;
endmodule
